mc_alu: RTL and testbench
=========================

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width (legal range 8..64).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request pulse; accepted only when busy=0.
REQ-005 The block SHALL have port A  input  WIDTH  operand A, sampled on the accepting edge.
REQ-006 The block SHALL have port B  input  WIDTH  operand B, sampled on the accepting edge.
REQ-007 The block SHALL have port ALUOp  input  3  operation code, sampled on the accepting edge.
REQ-008 The block SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; results are valid from this cycle on.
REQ-010 The block SHALL have port alu_res  output  WIDTH  primary result (low product, quotient, or logic/arith result).
REQ-011 The block SHALL have port alu_res_hi  output  WIDTH  high product or remainder; 0 for all other ops.
REQ-012 The block SHALL have port zero  output  1  high when the result is all-zero.
REQ-013 The block SHALL have port overflow  output  1  signed overflow (ADD/SUB) or divide-by-zero (DIVU).

Function
REQ-014 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed, result 1 or 0), 101 MULU, 110 DIVU, 111 XOR.
REQ-015 Single-cycle ops (ADD, SUB, AND, OR, SLT, XOR) SHALL register results on accepting edge k; done=1 for the following cycle only; busy stays 0.
REQ-016 MULU SHALL use a shift-add datapath with one iteration per cycle: busy=1 from edge k to edge k+WIDTH, done=1 in the cycle after edge k+WIDTH, busy=0 in that cycle; {alu_res_hi,alu_res} = A*B unsigned.
REQ-017 DIVU SHALL be restoring, with identical timing to MULU: alu_res=A/B and alu_res_hi=A%B, both unsigned.
REQ-018 DIVU with B=0 SHALL skip iteration and behave as single-cycle: alu_res=all-ones, alu_res_hi=A, overflow=1.
REQ-019 The FSM SHALL have states IDLE, ITER and FIN; transitions are IDLE->ITER on a MULU/DIVU start with B!=0; ITER->FIN when the iteration count reaches WIDTH; FIN->IDLE unconditionally. done SHALL be asserted in FIN or after a single-cycle accept.
REQ-020 start while busy=1 SHALL be ignored, with no effect on state, operands or outputs.
REQ-021 start in the done cycle SHALL be accepted (back-to-back operation is allowed).
REQ-022 Outputs SHALL hold their last values until the next completion; they SHALL NOT change mid-iteration.
REQ-023 zero SHALL equal ({alu_res_hi,alu_res}==0) for MULU and (alu_res==0) for all other ops.
REQ-024 overflow SHALL be computed from operand and result sign bits for ADD/SUB, and SHALL be 0 for all other ops except the DIVU-by-zero case.

Reset
REQ-025 While rst_n=0, state SHALL be IDLE, busy=0, done=0, alu_res=0, alu_res_hi=0, zero=0, overflow=0, and the iteration counter SHALL be 0.
REQ-026 Reset asserted mid-iteration SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package mc_alu_pkg SHALL hold the opcode constants and the FSM state enum.
REQ-029 The iterative multiply/divide datapath (accumulator, shift registers, counter) SHALL be the sub-module mc_alu_iter; single-cycle ops and the FSM SHALL stay in mc_alu.

Verification (WIDTH=32)
REQ-030 The bench SHALL cover: ADD A=FFFFFFFF, B=00000001 -> alu_res=0, zero=1, overflow=0, done 1 cycle after start; ADD 7FFFFFFF+1 -> 80000000, overflow=1.
REQ-031 The bench SHALL cover: SLT A=FFFFFFFF, B=00000001 -> alu_res=1; SUB 3-4 -> FFFFFFFF, overflow=0.
REQ-032 The bench SHALL cover: MULU 00010000*00010000 -> alu_res_hi=1, alu_res=0, zero=0, busy for exactly 32 cycles, then a single done pulse; a start at cycle 5 is ignored.
REQ-033 The bench SHALL cover: DIVU 7/2 -> alu_res=3, alu_res_hi=1 after 32 cycles; DIVU 5/0 -> alu_res=FFFFFFFF, alu_res_hi=5, overflow=1, done 1 cycle after start.
REQ-034 The bench SHALL cover: rst_n pulsed low at cycle 10 of a MULU -> all outputs 0, busy=0, no done; a subsequent ADD 3+4 gives 7.
REQ-035 The bench SHALL cover: back-to-back start in the done cycle of DIVU, issuing an AND -> accepted, with correct result one cycle later.

Source files
------------

// File: rtl/mc_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle ALU.
// No logic; imported by mc_alu.
package mc_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MULU = 3'b101;
  localparam logic [2:0] OP_DIVU = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mc_alu_iter.sv
// Shift-add multiplier / restoring divider, one iteration per step; last flags the WIDTH-th step.
// No backpressure: load restarts the datapath, step advances it; *_nxt give the post-step values.
module mc_alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opnd;
  logic             div_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: {acc,mq} holds partial product / multiplier. Divide: acc is the
  // partial remainder, mq shifts dividend bits out and quotient bits in.
  always_comb begin
    add_sum = {1'b0, acc} + {1'b0, (mq[0] ? opnd : '0)};
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {mq[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], mq[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mq    <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mq    <= a;
      opnd  <= b;
      div_q <= is_div;
      cnt   <= '0;
    end else if (step) begin
      acc <= hi_nxt;
      mq  <= lo_nxt;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: logic/arith ops complete in 1 cycle, MULU/DIVU in WIDTH cycles, done pulses once.
// start is ignored while busy; a start in the done cycle is accepted (back-to-back).
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] alu_res_hi,
  output logic             zero,
  output logic             overflow
);

  state_t state, state_nxt;

  logic             accept;
  logic             multi;
  logic             sc_done_q;
  logic             mul_q;
  logic             iter_last;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ov;

  assign accept = start && (state != ST_ITER);
  // Divide-by-zero bypasses iteration and completes on the single-cycle path.
  assign multi  = (ALUOp == OP_MULU) || ((ALUOp == OP_DIVU) && (B != '0));
  assign sum    = A + B;
  assign dif    = A - B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FIN returns to IDLE unless it is itself the accepting cycle of a new iterative op.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ITER: if (iter_last) state_nxt = ST_FIN;
      default: state_nxt = (accept && multi) ? ST_ITER : ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_ITER);
    done = (state == ST_FIN) || sc_done_q;
  end

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ov  = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        sc_res = sum;
        sc_ov  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ov  = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_DIVU: begin
        sc_res = '1;
        sc_hi  = A;
        sc_ov  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_done_q  <= 1'b0;
      mul_q      <= 1'b0;
      alu_res    <= '0;
      alu_res_hi <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sc_done_q <= accept && !multi;
      if (accept) mul_q <= (ALUOp == OP_MULU);
      if (accept && !multi) begin
        alu_res    <= sc_res;
        alu_res_hi <= sc_hi;
        zero       <= (sc_res == '0);
        overflow   <= sc_ov;
      end else if ((state == ST_ITER) && iter_last) begin
        alu_res    <= iter_lo;
        alu_res_hi <= iter_hi;
        zero       <= mul_q ? ({iter_hi, iter_lo} == '0) : (iter_lo == '0);
        overflow   <= 1'b0;
      end
    end
  end

  mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept && multi),
    .is_div (ALUOp == OP_DIVU),
    .step   (state == ST_ITER),
    .a      (A),
    .b      (B),
    .last   (iter_last),
    .lo_nxt (iter_lo),
    .hi_nxt (iter_hi)
  );

endmodule

// File: tb/tb_mc_alu.sv
// Randomised and directed bench for mc_alu (WIDTH=32) against an arithmetic reference model.
module tb_mc_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic        busy;
  logic        done;
  logic [31:0] alu_res;
  logic [31:0] alu_res_hi;
  logic        zero;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  mc_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .ALUOp      (ALUOp),
    .busy       (busy),
    .done       (done),
    .alu_res    (alu_res),
    .alu_res_hi (alu_res_hi),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results from plain arithmetic; lat is cycles from accept to done beyond the first.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] h,
                                output logic z, output logic o, output int lat);
    longint      s;
    logic [63:0] p;
    r = '0; h = '0; o = 1'b0; lat = 0; s = 0; p = '0;
    case (op)
      3'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = s[31:0];
        o = (s != longint'($signed(r)));
      end
      3'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = s[31:0];
        o = (s != longint'($signed(r)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
        h = p[63:32];
        lat = 32;
      end
      3'd6: begin
        if (b == 0) begin
          r = '1; h = a; o = 1'b1;
        end else begin
          r = a / b; h = a % b; lat = 32;
        end
      end
      default: r = a ^ b;
    endcase
    z = (op == 3'd5) ? ({h, r} == 64'd0) : (r == 32'd0);
  endfunction

  // Issues one op, returns in its done cycle; intr_at >= 0 fires a stray start mid-iteration.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int intr_at, input string tag);
    logic [31:0] er, eh, prev;
    logic        ez, eo;
    int          el, n;
    model(op, a, b, er, eh, ez, eo, el);
    prev  = alu_res;
    start = 1'b1; ALUOp = op; A = a; B = b;
    tick();
    start = 1'b0; A = $urandom; B = $urandom; ALUOp = 3'($urandom);
    n = 0;
    while (!done && n < 40) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_hold"}, alu_res, prev);
      if (n == intr_at) begin
        start = 1'b1; ALUOp = 3'b000; A = $urandom; B = $urandom;
      end
      tick();
      start = 1'b0;
      n++;
    end
    check({tag, "_lat"}, n, el);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_res"}, alu_res, er);
    check({tag, "_hi"}, alu_res_hi, eh);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_ovf"}, overflow, eo);
  endtask

  task automatic idle(input string tag);
    tick();
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; ALUOp = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", alu_res, 0);
    check("rst_hi", alu_res_hi, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFF, 32'h1, -1, "add_wrap");   idle("add_wrap");
    do_op(3'd0, 32'h7FFF_FFFF, 32'h1, -1, "add_ovf");    idle("add_ovf");
    do_op(3'd4, 32'hFFFF_FFFF, 32'h1, -1, "slt");        idle("slt");
    do_op(3'd1, 32'd3, 32'd4, -1, "sub");                idle("sub");
    do_op(3'd5, 32'h0001_0000, 32'h0001_0000, 5, "mulu"); idle("mulu");
    do_op(3'd6, 32'd7, 32'd2, -1, "divu");               idle("divu");
    do_op(3'd6, 32'd5, 32'd0, -1, "div0");               idle("div0");

    // Reset during a multiply aborts it with no trailing done.
    start = 1'b1; ALUOp = 3'd5; A = $urandom; B = $urandom | 32'h1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_res", alu_res, 0);
    check("mrst_hi", alu_res_hi, 0);
    check("mrst_zero", zero, 0);
    check("mrst_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      seen += int'(done) + int'(busy);
    end
    check("mrst_quiet", seen, 0);
    do_op(3'd0, 32'd3, 32'd4, -1, "post_rst");           idle("post_rst");

    do_op(3'd6, 32'd7, 32'd2, -1, "b2b_div");
    do_op(3'd2, 32'hF0F0_1234, 32'hFF00_FF0F, -1, "b2b_and");
    idle("b2b_and");

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      do_op(rop, ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1, "rnd");
      if ($urandom_range(0, 1) == 1) idle("rnd");
    end
    idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
